// File: rtl/match_collector.sv
// match_collector
//   Turns the PE array's per-cycle 4-lane match window into absolute byte
//   positions (word_idx*4 + lane). Non-empty windows are buffered in a FIFO
//   and emitted one position per handshake, lowest position first. The block
//   also counts matched lanes and flags the end of the stream.
//
//   Build option: define MATCH_COUNT_EN to enable the saturating match counter.
//   Without it, match_count is tied to zero.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        pulse; starts a new stream from IDLE or DONE
//   win_in       match window, bit k = match ending at lane k
//   win_valid    win_in valid
//   win_last     last beat of the stream (qualified by win_valid)
//   win_ready    a beat is accepted this cycle
//   pos_out      byte position of the current match
//   pos_valid    pos_out valid (registered)
//   pos_ready    consumer accepts pos_out
//   match_count  matched lanes this stream, saturating
//   overflow     sticky, word index wrapped this stream
//   done         stream fully drained, held until the next start
module match_collector #(
  parameter int POS_W = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       win_in,
  input  logic             win_valid,
  input  logic             win_last,
  output logic             win_ready,
  output logic [POS_W-1:0] pos_out,
  output logic             pos_valid,
  input  logic             pos_ready,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             done
);

  localparam int IW = POS_W - 2;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    widx_q, widx_d;
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    mem_idx  [DEPTH];
  logic [3:0]       mem_mask [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic [3:0]       ser_mask_q, ser_mask_d;
  logic [IW-1:0]    ser_idx_q, ser_idx_d;
  logic             pv_q, pv_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic       clear, accept, push, pop, fifo_empty;
  logic [3:0] rem;
  logic [1:0] lane_d;

  assign clear      = start && (state_q == S_IDLE || state_q == S_DONE);
  assign win_ready  = (state_q == S_RUN) && !full_q;
  assign accept     = win_valid && win_ready;
  assign push       = accept && (win_in != 4'd0);
  assign fifo_empty = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && win_last) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty && ser_mask_q == 4'd0) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Retire the presented lane first, so a mask that empties this cycle
    // can reload from the FIFO head with no bubble.
    rem = ser_mask_q;
    if (pv_q && pos_ready) rem = ser_mask_q & (ser_mask_q - 4'd1);

    pop        = 1'b0;
    ser_mask_d = rem;
    ser_idx_d  = ser_idx_q;
    if (rem == 4'd0 && !fifo_empty) begin
      pop        = 1'b1;
      ser_mask_d = mem_mask[rptr_q];
      ser_idx_d  = mem_idx[rptr_q];
    end

    if      (ser_mask_d[0]) lane_d = 2'd0;
    else if (ser_mask_d[1]) lane_d = 2'd1;
    else if (ser_mask_d[2]) lane_d = 2'd2;
    else if (ser_mask_d[3]) lane_d = 2'd3;
    else                    lane_d = 2'd0;

    pv_d   = (ser_mask_d != 4'd0);
    pos_d  = {ser_idx_d, lane_d};
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d = (cnt_d == (AW+1)'(DEPTH));
    widx_d = accept ? widx_q + IW'(1) : widx_q;
    ovf_d  = ovf_q || (accept && (&widx_q));

    if (clear) begin
      ser_mask_d = '0;
      ser_idx_d  = '0;
      pv_d       = 1'b0;
      pos_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
      full_d     = 1'b0;
      widx_d     = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx[wptr_q]  <= widx_q;
      mem_mask[wptr_q] <= win_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      widx_q     <= '0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      ser_mask_q <= '0;
      ser_idx_q  <= '0;
      pv_q       <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      ser_mask_q <= ser_mask_d;
      ser_idx_q  <= ser_idx_d;
      pv_q       <= pv_d;
      pos_q      <= pos_d;
    end
  end

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] mc_q, mc_d;
  logic [2:0]       popc;
  logic [CNT_W:0]   mc_sum;

  always_comb begin
    popc   = 3'(win_in[0]) + 3'(win_in[1]) + 3'(win_in[2]) + 3'(win_in[3]);
    mc_sum = {1'b0, mc_q} + (CNT_W+1)'(popc);
    mc_d   = mc_q;
    if (accept) mc_d = mc_sum[CNT_W] ? '1 : mc_sum[CNT_W-1:0];
    if (clear)  mc_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mc_q <= '0;
    else        mc_q <= mc_d;
  end

  assign match_count = mc_q;
`else
  assign match_count = '0;
`endif

  assign pos_out   = pos_q;
  assign pos_valid = pv_q;
  assign overflow  = ovf_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_match_collector.sv
module tb_match_collector;

`ifdef MATCH_COUNT_EN
  localparam int MC_ON = 1;
`else
  localparam int MC_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, win_valid, win_last, pos_ready;
  logic [3:0]  win_in;
  logic        win_ready, pos_valid, overflow, done;
  logic [15:0] pos_out, match_count;

  logic        s_start, s_win_valid, s_win_last, s_pos_ready;
  logic [3:0]  s_win_in;
  logic        s_win_ready, s_pos_valid, s_overflow, s_done;
  logic [3:0]  s_pos_out;
  logic [15:0] s_match_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int s_exp_q[$];

  always #5 clk = ~clk;

  match_collector #(.POS_W(16), .DEPTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .win_in(win_in),
    .win_valid(win_valid), .win_last(win_last), .win_ready(win_ready),
    .pos_out(pos_out), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .match_count(match_count), .overflow(overflow), .done(done)
  );

  match_collector #(.POS_W(4), .DEPTH(8), .CNT_W(16)) u_small (
    .clk(clk), .reset(rst_n), .start(s_start), .win_in(s_win_in),
    .win_valid(s_win_valid), .win_last(s_win_last), .win_ready(s_win_ready),
    .pos_out(s_pos_out), .pos_valid(s_pos_valid), .pos_ready(s_pos_ready),
    .match_count(s_match_count), .overflow(s_overflow), .done(s_done)
  );

  function automatic int mcx(input int v);
    return v * MC_ON;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: check any position handed over at this edge, then advance.
  task automatic cyc();
    if (pos_valid && pos_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pos", 32'(pos_valid), 32'd0);
      else                   chk("pos", 32'(pos_out), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
  endtask

  task automatic collect(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int sent;
    logic acc;

    rst_n = 1'b0; start = 1'b0; win_valid = 1'b0; win_last = 1'b0;
    win_in = 4'd0; pos_ready = 1'b1;
    s_start = 1'b0; s_win_valid = 1'b0; s_win_last = 1'b0;
    s_win_in = 4'd0; s_pos_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_win_ready", 32'(win_ready), 0);
    chk("rst_pos_valid", 32'(pos_valid), 0);
    chk("rst_pos_out", 32'(pos_out), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_done", 32'(done), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_win_ready", 32'(win_ready), 0);

    // T1: single beat 0101, exact latency
    pulse_start();
    chk("t1_win_ready", 32'(win_ready), 1);
    exp_q = '{0, 2};
    win_in = 4'b0101; win_valid = 1'b1; win_last = 1'b1;
    cyc();
    win_valid = 1'b0; win_last = 1'b0;
    chk("t1_t1_valid", 32'(pos_valid), 0);
    chk("t1_drain_ready", 32'(win_ready), 0);
    cyc();
    chk("t1_t2_valid", 32'(pos_valid), 1);
    chk("t1_t2_pos", 32'(pos_out), 0);
    cyc();
    chk("t1_t3_pos", 32'(pos_out), 2);
    cyc();
    chk("t1_t4_valid", 32'(pos_valid), 0);
    chk("t1_t4_done", 32'(done), 0);
    cyc();
    chk("t1_done", 32'(done), 1);
    chk("t1_count", 32'(match_count), 32'(mcx(2)));
    chk("t1_left", 32'(exp_q.size()), 0);

    // T2: zero-mask beats still advance word_idx
    pulse_start();
    chk("t2_cleared", 32'(done), 0);
    exp_q = '{11};
    win_valid = 1'b1;
    win_in = 4'b0000; cyc();
    win_in = 4'b0000; cyc();
    win_in = 4'b1000; win_last = 1'b1; cyc();
    win_valid = 1'b0; win_last = 1'b0;
    collect("t2", 20);
    chk("t2_count", 32'(match_count), 32'(mcx(1)));

    // T3: backpressure fills the buffer; release and drain 0..39 in order
    pos_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 40; i++) exp_q.push_back(i);
    sent = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      win_valid = (sent < 10); win_last = (sent == 9); win_in = 4'b1111;
      if (c == 5) chk("t3_hold_pos", 32'(pos_out), 0);
      if (c == 14) begin
        chk("t3_sent_full", 32'(sent), 9);
        chk("t3_ready_full", 32'(win_ready), 0);
        chk("t3_hold_valid", 32'(pos_valid), 1);
        chk("t3_hold_pos2", 32'(pos_out), 0);
      end
      if (c == 15) pos_ready = 1'b1;
      acc = win_valid && win_ready;
      cyc();
      if (acc) sent++;
    end
    win_valid = 1'b0; win_last = 1'b0;
    chk("t3_sent", 32'(sent), 10);
    chk("t3_done", 32'(done), 1);
    chk("t3_left", 32'(exp_q.size()), 0);
    chk("t3_count", 32'(match_count), 32'(mcx(40)));
    chk("t3_overflow", 32'(overflow), 0);

    // T4: start during RUN is ignored
    pulse_start();
    exp_q = '{0, 5};
    win_valid = 1'b1; win_in = 4'b0001; cyc();
    start = 1'b1; win_in = 4'b0010; win_last = 1'b1; cyc();
    start = 1'b0; win_valid = 1'b0; win_last = 1'b0;
    chk("t4_count", 32'(match_count), 32'(mcx(2)));
    collect("t4", 20);

    // T5: reset while draining discards buffered positions
    pos_ready = 1'b0;
    pulse_start();
    win_valid = 1'b1;
    win_in = 4'b0100; cyc();
    win_in = 4'b0010; cyc();
    win_in = 4'b1000; win_last = 1'b1; cyc();
    win_valid = 1'b0; win_last = 1'b0;
    cyc();
    chk("t5_pre_valid", 32'(pos_valid), 1);
    chk("t5_pre_pos", 32'(pos_out), 2);
    chk("t5_pre_count", 32'(match_count), 32'(mcx(3)));
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(pos_valid), 0);
    chk("t5_rst_pos", 32'(pos_out), 0);
    chk("t5_rst_count", 32'(match_count), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_ready", 32'(win_ready), 0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pos_ready = 1'b1;
    pulse_start();
    exp_q = '{0};
    win_valid = 1'b1; win_in = 4'b0001; win_last = 1'b1; cyc();
    win_valid = 1'b0; win_last = 1'b0;
    collect("t5", 20);
    chk("t5_count", 32'(match_count), 32'(mcx(1)));

    // T6: POS_W=4 instance, word index wraps after the 4th beat
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_exp_q = '{0, 4, 8, 12, 0};
    sent = 0;
    for (int c = 0; c < 40 && !s_done; c++) begin
      s_win_valid = (sent < 5); s_win_last = (sent == 4); s_win_in = 4'b0001;
      if (s_pos_valid && s_pos_ready) begin
        if (s_exp_q.size() == 0) chk("t6_unexpected", 32'(s_pos_valid), 0);
        else                     chk("t6_pos", 32'(s_pos_out), 32'(s_exp_q.pop_front()));
      end
      acc = s_win_valid && s_win_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent == 3) chk("t6_ovf_beat3", 32'(s_overflow), 0);
        if (sent == 4) chk("t6_ovf_beat4", 32'(s_overflow), 1);
      end
    end
    s_win_valid = 1'b0; s_win_last = 1'b0;
    chk("t6_done", 32'(s_done), 1);
    chk("t6_left", 32'(s_exp_q.size()), 0);
    chk("t6_ovf_sticky", 32'(s_overflow), 1);
    chk("t6_count", 32'(s_match_count), 32'(mcx(5)));
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("t6_ovf_cleared", 32'(s_overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
